// File: rtl/bounce_decoder.sv
// Loop-back monitor for a bouncing one-hot walker: decodes position/direction, locks to the
// sequence, counts end-of-travel reversals and flags malformed or out-of-order samples.
module bounce_decoder #(
   parameter int WIDTH = 8,
   parameter int PW    = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_en,
   input  logic             clear,
   input  logic [WIDTH-1:0] q_in,
   output logic [PW-1:0]    pos,
   output logic             pos_valid,
   output logic             dir,
   output logic             locked,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] bounce_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   // Encoding chosen so locked and dir are plain state-register bits.
   typedef enum logic [1:0] {
      SYNC = 2'b00,
      UP   = 2'b01,
      DOWN = 2'b11
   } state_t;

   localparam logic [1:0] E_NOT_ONEHOT = 2'd1;
   localparam logic [1:0] E_SEQUENCE   = 2'd2;
   localparam logic [1:0] E_STALL      = 2'd3;

   state_t            state, state_n;
   logic [PW-1:0]     idx, pos_n;
   logic              onehot, pos_valid_n, err_n, bump_n;
   logic [1:0]        code_n;
   int                idx_i, pos_i;

   assign locked = state[0];
   assign dir    = state[1];

   always_comb begin
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (q_in[i]) idx = PW'(i);
      end
      onehot = (q_in != '0) && ((q_in & (q_in - WIDTH'(1))) == '0);
      idx_i  = int'(idx);
      pos_i  = int'(pos);
   end

   always_comb begin
      state_n     = state;
      pos_n       = pos;
      pos_valid_n = pos_valid;
      err_n       = 1'b0;
      code_n      = err_code;
      bump_n      = 1'b0;
      if (sample_en) begin
         if (!onehot) begin
            state_n     = SYNC;
            pos_valid_n = 1'b0;
            err_n       = 1'b1;
            code_n      = E_NOT_ONEHOT;
         end else begin
            pos_n       = idx;
            pos_valid_n = 1'b1;
            case (state)
               SYNC: begin
                  if (!pos_valid) begin
                     if (idx_i == 0)              state_n = UP;
                     else if (idx_i == WIDTH - 1) state_n = DOWN;
                  end else if (idx_i == pos_i + 1) begin
                     state_n = (idx_i == WIDTH - 1) ? DOWN : UP;
                  end else if (idx_i == pos_i - 1) begin
                     state_n = (idx_i == 0) ? UP : DOWN;
                  end else if (idx_i == pos_i) begin
                     err_n  = 1'b1;
                     code_n = E_STALL;
                  end
               end
               UP, DOWN: begin
                  if ((state == UP && idx_i == pos_i + 1) ||
                      (state == DOWN && idx_i == pos_i - 1)) begin
                     if (state == UP && idx_i == WIDTH - 1) begin
                        state_n = DOWN;
                        bump_n  = 1'b1;
                     end else if (state == DOWN && idx_i == 0) begin
                        state_n = UP;
                        bump_n  = 1'b1;
                     end
                  end else begin
                     state_n = SYNC;
                     err_n   = 1'b1;
                     code_n  = (idx_i == pos_i) ? E_STALL : E_SEQUENCE;
                  end
               end
               default: state_n = SYNC;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= SYNC;
         pos        <= '0;
         pos_valid  <= 1'b0;
         err        <= 1'b0;
         err_code   <= 2'd0;
         bounce_cnt <= '0;
         err_cnt    <= '0;
      end else begin
         state     <= state_n;
         pos       <= pos_n;
         pos_valid <= pos_valid_n;
         err       <= err_n;
         // clear wins over any same-cycle counter or code update.
         if (clear) begin
            err_code   <= 2'd0;
            bounce_cnt <= '0;
            err_cnt    <= '0;
         end else begin
            err_code <= code_n;
            if (bump_n && bounce_cnt != '1) bounce_cnt <= bounce_cnt + CNT_W'(1);
            if (err_n && err_cnt != '1)     err_cnt    <= err_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_bounce_decoder.sv
// Directed bench for bounce_decoder: lock/track, error classes, gating, clear, saturation, reset.
module tb_bounce_decoder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sample_en = 1'b0, clear = 1'b0;
   logic [7:0]  q_in = 8'h00;
   logic [2:0]  pos;
   logic        pos_valid, dir, locked, err;
   logic [1:0]  err_code;
   logic [15:0] bounce_cnt, err_cnt;

   logic        sample_en2 = 1'b0;
   logic [7:0]  q_in2 = 8'h00;
   logic [2:0]  pos2;
   logic        pos_valid2, dir2, locked2, err2;
   logic [1:0]  err_code2;
   logic [1:0]  bounce_cnt2, err_cnt2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bounce_decoder #(.WIDTH(8), .PW(3), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .sample_en(sample_en), .clear(clear), .q_in(q_in),
      .pos(pos), .pos_valid(pos_valid), .dir(dir), .locked(locked), .err(err),
      .err_code(err_code), .bounce_cnt(bounce_cnt), .err_cnt(err_cnt)
   );

   bounce_decoder #(.WIDTH(8), .PW(3), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .sample_en(sample_en2), .clear(1'b0), .q_in(q_in2),
      .pos(pos2), .pos_valid(pos_valid2), .dir(dir2), .locked(locked2), .err(err2),
      .err_code(err_code2), .bounce_cnt(bounce_cnt2), .err_cnt(err_cnt2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive at negedge, sample 1 time unit after the following posedge.
   task automatic step(input logic [7:0] q, input logic en, input logic clr);
      @(negedge clk);
      q_in = q; sample_en = en; clear = clr;
      @(posedge clk);
      #1;
      sample_en = 1'b0; clear = 1'b0;
   endtask

   task automatic step2(input logic [7:0] q);
      @(negedge clk);
      q_in2 = q; sample_en2 = 1'b1;
      @(posedge clk);
      #1;
      sample_en2 = 1'b0;
   endtask

   // Asserted between edges; outputs must drop before any clock edge.
   task automatic apply_reset();
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_pos", 32'(pos), 0);
      check("rst_pos_valid", 32'(pos_valid), 0);
      check("rst_locked", 32'(locked), 0);
      check("rst_dir", 32'(dir), 0);
      check("rst_err", 32'(err), 0);
      check("rst_err_code", 32'(err_code), 0);
      check("rst_bounce", 32'(bounce_cnt), 0);
      check("rst_err_cnt", 32'(err_cnt), 0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Walk 0..7..0,1; optionally insert held cycles with junk input between samples.
   task automatic lock_and_track(input bit gated);
      int seq[16] = '{0,1,2,3,4,5,6,7,6,5,4,3,2,1,0,1};
      logic       exp_dir;
      logic [2:0] exp_pos;
      int         exp_b;
      exp_dir = 1'b0;
      exp_b   = 0;
      for (int k = 0; k < 16; k++) begin
         step(8'(1 << seq[k]), 1'b1, 1'b0);
         if (seq[k] == 7) begin exp_dir = 1'b1; exp_b++; end
         if (seq[k] == 0) begin
            if (k != 0) exp_b++;
            exp_dir = 1'b0;
         end
         exp_pos = 3'(seq[k]);
         check("t1_pos", 32'(pos), 32'(exp_pos));
         check("t1_locked", 32'(locked), 1);
         check("t1_dir", 32'(dir), 32'(exp_dir));
         check("t1_bounce", 32'(bounce_cnt), 32'(exp_b));
         check("t1_err", 32'(err), 0);
         if (gated) begin
            step(8'hFF, 1'b0, 1'b0);
            check("t4_hold_pos", 32'(pos), 32'(exp_pos));
            check("t4_hold_dir", 32'(dir), 32'(exp_dir));
            check("t4_hold_locked", 32'(locked), 1);
            check("t4_hold_err", 32'(err), 0);
            check("t4_hold_err_cnt", 32'(err_cnt), 0);
         end
      end
      check("t1_bounce_final", 32'(bounce_cnt), 2);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset_locked", 32'(locked), 0);
      check("reset_pos_valid", 32'(pos_valid), 0);

      // T1: lock and track, ending UP at pos 1.
      lock_and_track(1'b0);

      // T2: not one-hot while locked at pos 3.
      step(8'h04, 1'b1, 1'b0);
      step(8'h08, 1'b1, 1'b0);
      check("t2_pre_pos", 32'(pos), 3);
      step(8'h30, 1'b1, 1'b0);
      check("t2_err", 32'(err), 1);
      check("t2_code", 32'(err_code), 1);
      check("t2_locked", 32'(locked), 0);
      check("t2_pos_valid", 32'(pos_valid), 0);
      check("t2_pos", 32'(pos), 3);
      check("t2_err_cnt", 32'(err_cnt), 1);
      step(8'h10, 1'b1, 1'b0);
      check("t2_resync_locked", 32'(locked), 0);
      check("t2_resync_pos", 32'(pos), 4);
      check("t2_resync_err", 32'(err), 0);
      step(8'h20, 1'b1, 1'b0);
      check("t2_relock", 32'(locked), 1);
      check("t2_relock_dir", 32'(dir), 0);
      check("t2_relock_pos", 32'(pos), 5);

      // Reset mid-run, then acquire at the top end.
      apply_reset();
      step(8'h80, 1'b1, 1'b0);
      check("acq_top_locked", 32'(locked), 1);
      check("acq_top_dir", 32'(dir), 1);
      check("acq_top_pos", 32'(pos), 7);
      check("acq_top_bounce", 32'(bounce_cnt), 0);

      // T3: skip from pos 2 to idx 4.
      apply_reset();
      step(8'h01, 1'b1, 1'b0);
      step(8'h02, 1'b1, 1'b0);
      step(8'h04, 1'b1, 1'b0);
      step(8'h10, 1'b1, 1'b0);
      check("t3_err", 32'(err), 1);
      check("t3_code", 32'(err_code), 2);
      check("t3_locked", 32'(locked), 0);
      check("t3_pos", 32'(pos), 4);
      step(8'h20, 1'b1, 1'b0);
      check("t3_relock", 32'(locked), 1);
      check("t3_dir", 32'(dir), 0);
      check("t3_bounce", 32'(bounce_cnt), 0);

      // T4: idx 3 twice (sequence error then stall in SYNC), then stall while locked.
      step(8'h08, 1'b1, 1'b0);
      check("t4_seq_code", 32'(err_code), 2);
      check("t4_seq_cnt", 32'(err_cnt), 2);
      step(8'h08, 1'b1, 1'b0);
      check("t4_stall_err", 32'(err), 1);
      check("t4_stall_code", 32'(err_code), 3);
      check("t4_stall_cnt", 32'(err_cnt), 3);
      step(8'h10, 1'b1, 1'b0);
      check("t4_lock", 32'(locked), 1);
      check("t4_lock_err", 32'(err), 0);
      step(8'h10, 1'b1, 1'b0);
      check("t4_lstall_code", 32'(err_code), 3);
      check("t4_lstall_locked", 32'(locked), 0);
      check("t4_lstall_cnt", 32'(err_cnt), 4);

      // T4: gated rerun of T1.
      apply_reset();
      lock_and_track(1'b1);

      // T5: clear on the idx=7 sample, then clear overriding an error.
      for (int k = 2; k <= 6; k++) step(8'(1 << k), 1'b1, 1'b0);
      check("t5_pre_bounce", 32'(bounce_cnt), 2);
      step(8'h80, 1'b1, 1'b1);
      check("t5_clr_bounce", 32'(bounce_cnt), 0);
      check("t5_clr_dir", 32'(dir), 1);
      check("t5_clr_pos", 32'(pos), 7);
      step(8'h00, 1'b1, 1'b1);
      check("t5_clr_err_pulse", 32'(err), 1);
      check("t5_clr_code", 32'(err_code), 0);
      check("t5_clr_err_cnt", 32'(err_cnt), 0);
      check("t5_clr_locked", 32'(locked), 0);

      // T5: saturation on the 2-bit counter instance, five bounces.
      apply_reset();
      step2(8'h01);
      for (int b = 1; b <= 5; b++) begin
         for (int j = 1; j <= 7; j++) step2(8'(1 << ((b % 2 == 1) ? j : 7 - j)));
         check("t5_sat_bounce", 32'(bounce_cnt2), 32'((b > 3) ? 3 : b));
      end
      check("t5_sat_err", 32'(err_cnt2), 0);
      check("t5_sat_dir", 32'(dir2), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
